// File: rtl/banked_regfile_pkg.sv
// Shared address constants and clear-engine state type for banked_regfile.
package regfile_pkg;

    localparam logic [3:0] SCRATCH_BASE = 4'h8;
    localparam logic [3:0] REG_IRA      = 4'hC;
    localparam logic [3:0] REG_SP       = 4'hD;
    localparam logic [3:0] REG_SR       = 4'hE;
    localparam logic [3:0] REG_PC       = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clear_state_t;

endpackage

// File: rtl/banked_regfile_if.sv
// Decode-side bus of the banked register file: read ports, write port, SP/SR/PC views,
// bank-clear handshake, error flag and clear-engine state for observation.
interface banked_regfile_if #(
    parameter int DATA_W     = 16,
    parameter int BANKS      = 256,
    parameter int READ_PORTS = 3
);
    import regfile_pkg::*;

    localparam int BANK_W = $clog2(BANKS);

    logic [BANK_W-1:0]                  bank_sel;
    logic [READ_PORTS-1:0][3:0]         read_addr;
    logic [READ_PORTS-1:0][DATA_W-1:0]  read_data;
    logic [3:0]                         write_addr;
    logic [DATA_W-1:0]                  write_data;
    logic                               write_en;
    logic [DATA_W-1:0]                  sp;
    logic [DATA_W-1:0]                  sr;
    logic [DATA_W-1:0]                  pc;
    // Clear handshake: a request is accepted on any rising edge where
    // clear_req and clear_ready are both high; clear_done pulses once at the end.
    logic                               clear_req;
    logic [BANK_W-1:0]                  clear_bank;
    logic                               clear_ready;
    logic                               clear_busy;
    logic                               clear_done;
    logic                               ro_write_err;
    clear_state_t                       clear_state;

    modport master (
        output bank_sel, read_addr, write_addr, write_data, write_en,
        output sp, sr, pc, clear_req, clear_bank,
        input  read_data, clear_ready, clear_busy, clear_done, ro_write_err, clear_state
    );

    modport slave (
        input  bank_sel, read_addr, write_addr, write_data, write_en,
        input  sp, sr, pc, clear_req, clear_bank,
        output read_data, clear_ready, clear_busy, clear_done, ro_write_err, clear_state
    );

endinterface

// File: rtl/banked_regfile_read_mux.sv
// One read port: address decode over bank window, scratch, IRA and SP/SR/PC views.
// With REGFILE_BYPASS_EN defined, a same-cycle user write to the addressed register is forwarded.
module regfile_read_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]             read_addr,
    input  logic [DATA_W-1:0]      bank_word,
    input  logic [3:0][DATA_W-1:0] scratch,
    input  logic [DATA_W-1:0]      ira,
    input  logic [DATA_W-1:0]      sp,
    input  logic [DATA_W-1:0]      sr,
    input  logic [DATA_W-1:0]      pc,
    input  logic                   write_en,
    input  logic [3:0]             write_addr,
    input  logic [DATA_W-1:0]      write_data,
    output logic [DATA_W-1:0]      read_data
);

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{write_en, write_addr, write_data};
`endif

    always_comb begin
        read_data = bank_word;
        if (read_addr == REG_IRA) begin
            read_data = ira;
        end else if (read_addr == REG_SP) begin
            read_data = sp;
        end else if (read_addr == REG_SR) begin
            read_data = sr;
        end else if (read_addr == REG_PC) begin
            read_data = pc;
        end else if (read_addr[3:2] == SCRATCH_BASE[3:2]) begin
            read_data = scratch[read_addr[1:0]];
        end
`ifdef REGFILE_BYPASS_EN
        // Both sides use the current bank_sel, so an address match means the same register.
        if (write_en && (write_addr == read_addr) && (write_addr < REG_SP)) begin
            read_data = write_data;
        end
`endif
    end

endmodule

// File: rtl/banked_regfile.sv
// Banked register file with N combinational read ports and a background bank-clear engine.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module banked_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BANKS      = 256,
    parameter int READ_PORTS = 3
) (
    input  logic             clock,
    input  logic             reset,
    banked_regfile_if.slave  bus
);

    localparam int BANK_W = $clog2(BANKS);

    logic [DATA_W-1:0]             bank_mem [0:BANKS*8-1];
    logic [3:0][DATA_W-1:0]        scratch_q;
    logic [DATA_W-1:0]             ira_q;
    logic                          ro_err_q;

    clear_state_t                  state_q, state_nxt;
    logic [BANK_W-1:0]             clr_bank_q;
    logic [2:0]                    clr_idx_q;

    logic                          user_bank_we;
    logic [BANK_W+2:0]             user_idx;
    logic                          clr_we;
    logic [BANK_W+2:0]             clr_idx;
    logic                          clr_collide;

    assign user_bank_we = bus.write_en && !bus.write_addr[3];
    assign user_idx     = {bus.bank_sel, bus.write_addr[2:0]};
    assign clr_we       = (state_q == CLEAR) && !reset;
    assign clr_idx      = {clr_bank_q, clr_idx_q};
    // A user write landing on the register being zeroed this edge takes priority.
    assign clr_collide  = user_bank_we && (user_idx == clr_idx);

    always_ff @(posedge clock) begin
        if (clr_we && !clr_collide) begin
            bank_mem[clr_idx] <= '0;
        end
        if (user_bank_we) begin
            bank_mem[user_idx] <= bus.write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_q <= '0;
            ira_q     <= '0;
            ro_err_q  <= 1'b0;
        end else if (bus.write_en) begin
            if (bus.write_addr == REG_IRA) begin
                ira_q <= bus.write_data;
            end else if (bus.write_addr >= REG_SP) begin
                ro_err_q <= 1'b1;
            end else if (bus.write_addr[3:2] == SCRATCH_BASE[3:2]) begin
                scratch_q[bus.write_addr[1:0]] <= bus.write_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_idx_q <= 3'd0;
        end else begin
            state_q <= state_nxt;
            if ((state_q == IDLE) && bus.clear_req) begin
                clr_bank_q <= bus.clear_bank;
                clr_idx_q  <= 3'd0;
            end else if (state_q == CLEAR) begin
                clr_idx_q <= clr_idx_q + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt       = state_q;
        bus.clear_ready = 1'b0;
        bus.clear_busy  = 1'b0;
        bus.clear_done  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.clear_ready = 1'b1;
                if (bus.clear_req) state_nxt = CLEAR;
            end
            CLEAR: begin
                bus.clear_busy = 1'b1;
                if (clr_idx_q == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                bus.clear_done = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ro_write_err = ro_err_q;
    assign bus.clear_state  = state_q;

    logic [READ_PORTS-1:0][DATA_W-1:0] rd_data;
    logic [READ_PORTS-1:0][DATA_W-1:0] bank_word;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        assign bank_word[p] = bank_mem[{bus.bank_sel, bus.read_addr[p][2:0]}];

        regfile_read_mux #(.DATA_W(DATA_W)) u_mux (
            .read_addr  (bus.read_addr[p]),
            .bank_word  (bank_word[p]),
            .scratch    (scratch_q),
            .ira        (ira_q),
            .sp         (bus.sp),
            .sr         (bus.sr),
            .pc         (bus.pc),
            .write_en   (bus.write_en),
            .write_addr (bus.write_addr),
            .write_data (bus.write_data),
            .read_data  (rd_data[p])
        );
    end

    assign bus.read_data = rd_data;

endmodule

// File: tb/tb_banked_regfile.sv
// Directed bench for banked_regfile with a per-cycle reference model and literal spot checks.
`timescale 1ns/1ps
module tb_banked_regfile;
    import regfile_pkg::*;

    localparam int NP = 3;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    banked_regfile_if #(.DATA_W(16), .BANKS(256), .READ_PORTS(NP)) bus ();

    banked_regfile #(.DATA_W(16), .BANKS(256), .READ_PORTS(NP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [15:0] m_bank [int];
    logic [15:0] m_scratch [4];
    logic [15:0] m_ira;
    bit          m_err;
    int          m_pend [$];
    int          m_clr_bank;
    bit          m_done;

    always @(posedge clock) begin
        bit was_done;
        int i;
        if (reset) begin
            for (int k = 0; k < 4; k++) m_scratch[k] = '0;
            m_ira  = '0;
            m_err  = 0;
            m_pend.delete();
            m_done = 0;
        end else begin
            was_done = m_done;
            m_done   = 0;
            if (m_pend.size() > 0) begin
                i = m_pend.pop_front();
                m_bank[m_clr_bank * 8 + i] = '0;
                if (m_pend.size() == 0) m_done = 1;
            end else if (!was_done && bus.clear_req) begin
                m_clr_bank = int'(bus.clear_bank);
                for (int k = 0; k < 8; k++) m_pend.push_back(k);
            end
            // The user write is applied after the zero, so it wins a collision.
            if (bus.write_en) begin
                if (bus.write_addr < 4'h8) m_bank[int'(bus.bank_sel) * 8 + int'(bus.write_addr[2:0])] = bus.write_data;
                else if (bus.write_addr < 4'hC) m_scratch[bus.write_addr[1:0]] = bus.write_data;
                else if (bus.write_addr == 4'hC) m_ira = bus.write_data;
                else m_err = 1;
            end
        end
    end

    function automatic logic [15:0] m_read(input logic [3:0] a, output bit known);
        int key;
        known = 1;
`ifdef REGFILE_BYPASS_EN
        if (bus.write_en && bus.write_addr == a && a <= 4'hC) return bus.write_data;
`endif
        if (a < 4'h8) begin
            key = int'(bus.bank_sel) * 8 + int'(a[2:0]);
            if (m_bank.exists(key)) return m_bank[key];
            known = 0;
            return '0;
        end
        if (a < 4'hC) return m_scratch[a[1:0]];
        if (a == 4'hC) return m_ira;
        if (a == 4'hD) return bus.sp;
        if (a == 4'hE) return bus.sr;
        return bus.pc;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        logic [15:0] exp_q [$];
        bit known;
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                exp_q.push_back(m_read(bus.read_addr[p], known));
                if (known) chk($sformatf("model_rd%0d", p), bus.read_data[p], exp_q.pop_back());
                else void'(exp_q.pop_back());
            end
            chk("model_busy",  bus.clear_busy,   m_pend.size() > 0);
            chk("model_done",  bus.clear_done,   m_done);
            chk("model_ready", bus.clear_ready,  (m_pend.size() == 0) && !m_done);
            chk("model_err",   bus.ro_write_err, m_err);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.write_en   = 1'b1;
        bus.write_addr = a;
        bus.write_data = d;
        tick();
        bus.write_en   = 1'b0;
    endtask

    task automatic rd_chk(input int p, input logic [3:0] a, input logic [15:0] exp, input string name);
        bus.read_addr[p] = a;
        #1;
        chk(name, bus.read_data[p], exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    logic [15:0] ro_exp [8];

    initial begin
        reset          = 1'b1;
        bus.bank_sel   = '0;
        bus.read_addr  = '0;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.write_en   = 1'b0;
        bus.sp         = 16'h1111;
        bus.sr         = 16'h0300;
        bus.pc         = 16'h2222;
        bus.clear_req  = 1'b0;
        bus.clear_bank = '0;
        do_reset();

        // Reset state and fixed views
        ro_exp = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1111, 16'h0300, 16'h2222};
        for (int a = 8; a < 16; a++)
            rd_chk(a % NP, 4'(a), ro_exp[a - 8], $sformatf("reset_rd_%h", a));
        chk("reset_ready", bus.clear_ready, 1);
        chk("reset_busy",  bus.clear_busy,  0);
        chk("reset_done",  bus.clear_done,  0);
        chk("reset_err",   bus.ro_write_err, 0);

        // Bank selection
        bus.bank_sel = 8'd3; wr(4'h5, 16'hBEEF);
        bus.bank_sel = 8'd4; wr(4'h5, 16'h1234);
        rd_chk(1, 4'h5, 16'h1234, "bank4_r5");
        bus.bank_sel = 8'd3;
        rd_chk(1, 4'h5, 16'hBEEF, "bank3_r5");

        // Read-only write
        bus.write_en = 1'b1; bus.write_addr = 4'hE; bus.write_data = 16'hAAAA;
        #1 chk("err_before_edge", bus.ro_write_err, 0);
        tick();
        bus.write_en = 1'b0;
        rd_chk(2, 4'hE, 16'h0300, "sr_unchanged");
        chk("err_set", bus.ro_write_err, 1);
        repeat (3) tick();
        chk("err_held", bus.ro_write_err, 1);

        // Full clear of bank 7, bank 6 as witness
        bus.bank_sel = 8'd7;
        for (int i = 0; i < 8; i++) wr(4'(i), 16'hFFFF);
        bus.bank_sel = 8'd6;
        for (int i = 0; i < 8; i++) wr(4'(i), 16'h6000 + 16'(i));
        bus.clear_req = 1'b1; bus.clear_bank = 8'd7;
        tick();
        bus.clear_req = 1'b0;
        chk("clr_ready_low", bus.clear_ready, 0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("clr_busy_c%0d", c), bus.clear_busy, 1);
            chk($sformatf("clr_nodone_c%0d", c), bus.clear_done, 0);
            tick();
        end
        chk("clr_done_pulse", bus.clear_done, 1);
        chk("clr_busy_end",   bus.clear_busy, 0);
        tick();
        chk("clr_done_gone",  bus.clear_done, 0);
        chk("clr_ready_back", bus.clear_ready, 1);
        bus.bank_sel = 8'd7;
        for (int i = 0; i < 8; i++) rd_chk(0, 4'(i), 16'h0, $sformatf("b7_r%0d_zero", i));
        bus.bank_sel = 8'd6;
        for (int i = 0; i < 8; i++) rd_chk(0, 4'(i), 16'h6000 + 16'(i), $sformatf("b6_r%0d_kept", i));

        // Collisions during a bank-7 clear
        bus.bank_sel = 8'd7;
        for (int i = 0; i < 8; i++) wr(4'(i), 16'hFFFF);
        bus.clear_req = 1'b1; bus.clear_bank = 8'd7;
        bus.bank_sel = 8'd6;
        tick();
        bus.clear_req = 1'b0;
        tick();
        bus.bank_sel = 8'd7; wr(4'h6, 16'h6666);
        wr(4'h2, 16'h5555);
        bus.bank_sel = 8'd6;
        repeat (5) tick();
        chk("coll_done", bus.clear_done, 1);
        bus.clear_req = 1'b1; bus.clear_bank = 8'd6;
        tick();
        bus.clear_req = 1'b0;
        chk("done_ignores_req", bus.clear_busy, 0);
        tick();
        chk("done_ignores_req2", bus.clear_busy, 0);
        bus.bank_sel = 8'd7;
        rd_chk(0, 4'h2, 16'h5555, "coll_r2_user");
        rd_chk(1, 4'h6, 16'h0000, "coll_r6_zero");
        rd_chk(2, 4'h3, 16'h0000, "coll_r3_zero");
        bus.bank_sel = 8'd6;
        rd_chk(0, 4'h7, 16'h6007, "coll_b6_r7");

        // Same-cycle IRA write with a reader on port 2
        bus.read_addr[2] = 4'hC;
        bus.write_en = 1'b1; bus.write_addr = 4'hC; bus.write_data = 16'h0ABC;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("ira_same_cycle", bus.read_data[2], 16'h0ABC);
`else
        chk("ira_same_cycle", bus.read_data[2], 16'h0000);
`endif
        tick();
        bus.write_en = 1'b0;
        rd_chk(2, 4'hC, 16'h0ABC, "ira_after_edge");

        // Reset is the only way to clear the error flag
        do_reset();
        #1 chk("err_cleared", bus.ro_write_err, 0);
        rd_chk(2, 4'hC, 16'h0000, "ira_reset");

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/banked_regfile.md
Name: banked_regfile

Overview:
- Parametrised successor to the CPU register file: banked general registers, scratch registers, IRA, plus read-only views of SP/SR/PC.
- Adds N read ports and an explicit bank-select input in place of the hardwired SR[15:8].
- Adds a background bank-clear engine with a request/ready/done handshake, and a registered error flag for writes to read-only registers.
- Sits between decode and the ALU/memory stages.

Parameters:
DATA_W, 16, register width in bits
BANKS, 256, number of 8-register banks; must be a power of 2, at least 2
READ_PORTS, 3, number of independent combinational read ports
BANK_W, $clog2(BANKS), localparam, width of bank indices

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
bank_sel  in  BANK_W  active bank for the r0-r7 window (normally driven from SR[15:8])
read_addr  in  READ_PORTS x 4  read addresses, one per port
read_data  out  READ_PORTS x DATA_W  read data, one per port
write_addr  in  4  write address
write_data  in  DATA_W  write data
write_en  in  1  write strobe
sp, sr, pc  in  DATA_W each  live values of SP, SR, PC (read-only here)
clear_req  in  1  request to zero one bank
clear_bank  in  BANK_W  bank to zero; sampled when the request is accepted
clear_ready  out  1  high when a clear request can be accepted
clear_busy  out  1  high while the clear engine is running
clear_done  out  1  one-cycle pulse when a clear completes
ro_write_err  out  1  registered flag for writes to read-only addresses

Behaviour:
- Address map (fixed 4-bit):
  - 0x0-0x7: bank[bank_sel][addr[2:0]]
  - 0x8-0xB: scratch[addr[1:0]]
  - 0xC: IRA
  - 0xD: SP, 0xE: SR, 0xF: PC (all three read-only)
- Reads: purely combinational, zero latency, independent per port. A read reflects the state before the current edge.
- Writes:
  - Take effect on the rising edge when write_en=1.
  - Bank-window writes use the bank_sel value present in that cycle.
  - Writes to 0xD-0xF are dropped. ro_write_err is set to 1 on the next cycle and stays set until reset. Only reset clears it.
- Reset:
  - Scratch[0..3] and IRA are zeroed.
  - Bank storage is not reset.
  - Clear FSM goes to IDLE.
  - Outputs after reset: clear_ready=1, clear_busy=0, clear_done=0, ro_write_err=0.
  - A reset during CLEAR aborts the clear; registers already zeroed stay zero, the rest keep their contents.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clear_ready=1. When clear_req=1, latch clear_bank, set idx=0, go to CLEAR.
  - CLEAR: clear_busy=1, clear_ready=0. Each cycle write 0 to bank[latched][idx] and increment idx. After idx=7 is written, go to DONE. A clear takes exactly 8 cycles in CLEAR.
  - DONE: clear_done=1 for one cycle, then return to IDLE. clear_req is ignored in DONE.
  - Request-to-done latency: 9 cycles after the accepting edge.
- Collisions during CLEAR:
  - If a user write targets the same bank and the same idx in the same cycle, the user write wins and the engine's zero is discarded.
  - A user write to a not-yet-cleared register of that bank is later overwritten with 0.
  - A user write to an already-cleared register persists.
  - Writes and reads to other banks are unaffected.
- bank_sel may change in any cycle, including during CLEAR; the clear always targets the latched bank.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if write_en=1 and write_addr maps to a writable register that a read port addresses in the same cycle (0x8-0xC, or 0x0-0x7 with the same bank_sel), that port returns write_data combinationally. The clear engine's zero writes are never forwarded.
- Undefined: reads return the stored pre-edge value.

Decomposition:
- Package regfile_pkg holds:
  - address constants: REG_IRA=4'hC, REG_SP=4'hD, REG_SR=4'hE, REG_PC=4'hF, SCRATCH_BASE=4'h8
  - clear_state_t enum {IDLE, CLEAR, DONE}
- One sub-module, regfile_read_mux: a single read port's address decode and mux, including the bypass logic. Instantiate it READ_PORTS times with a generate loop.

Test Plan:
- Reset, then read every address with sp=0x1111, sr=0x0300, pc=0x2222 -> 0x8-0xC read 0; 0xD/0xE/0xF read 0x1111/0x0300/0x2222; clear_ready=1.
- bank_sel=3, write 0xBEEF to r5; bank_sel=4, write 0x1234 to r5 -> r5 reads 0x1234 with bank_sel=4 and 0xBEEF with bank_sel=3.
- Write 0xAAAA to addr 0xE -> SR view unchanged; ro_write_err=1 from the next cycle, held until reset.
- Fill bank 7 with 0xFFFF, pulse clear_req with clear_bank=7 -> clear_busy high for 8 cycles, clear_done pulse at cycle 9, all bank 7 registers read 0, bank 6 untouched.
- During a bank-7 clear: user write 0x5555 to r2 on the cycle idx=2 -> r2=0x5555. User write 0x6666 to r6 while idx=1 -> r6=0.
- With REGFILE_BYPASS_EN: write 0x0ABC to IRA while read port 2 reads 0xC -> port 2 shows 0x0ABC in the same cycle. Without the macro -> port 2 shows the old value.
